// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level capture, mask, force,
// write-1-to-clear, fixed-priority vector and one registered CPU interrupt.
module irq_aggregator #(
   parameter int          N_SRC        = 8,
   parameter logic [15:0] EDGE_DEFAULT = 16'h0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [15:0]      writedata,
   output logic [15:0]      readdata,
   output logic             cpu_irq
);

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_FORCE   = 3'd3;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
   localparam logic [2:0] ADDR_VECTOR  = 3'd5;

   logic [N_SRC-1:0] pending_reg;
   logic [N_SRC-1:0] pending_next;
   logic [N_SRC-1:0] mask_reg;
   logic [N_SRC-1:0] edge_sel_reg;
   logic [N_SRC-1:0] irq_prev_reg;
   logic [N_SRC-1:0] wdata;
   logic [N_SRC-1:0] clr;
   logic [N_SRC-1:0] frc;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] active;
   logic             wr_en;
   logic [3:0]       vec_idx;
   logic [15:0]      vector;
   logic [15:0]      read_next;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[N_SRC-1:0];
   assign unused_wdata = ^writedata;
   assign clr          = (wr_en && address == ADDR_PENDING) ? wdata : '0;
   assign frc          = (wr_en && address == ADDR_FORCE)   ? wdata : '0;
   assign rise         = irq_src & ~irq_prev_reg;
   assign active       = pending_reg & mask_reg;

   // Set terms are ORed after the clear so a same-cycle event is never lost.
   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
         assign pending_next[gi] = edge_sel_reg[gi]
                                 ? ((pending_reg[gi] & ~clr[gi]) | rise[gi] | frc[gi])
                                 : (irq_src[gi] | frc[gi]);
      end
   endgenerate

   // Scan from the top down so the lowest active index is the one left standing.
   always_comb begin
      vec_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) vec_idx = 4'(i);
      end
      vector = (|active) ? {1'b1, 11'b0, vec_idx} : 16'h0000;
   end

   always_comb begin
      read_next = '0;
      case (address)
         ADDR_PENDING: read_next = 16'(pending_reg);
         ADDR_MASK:    read_next = 16'(mask_reg);
         ADDR_EDGE:    read_next = 16'(edge_sel_reg);
         ADDR_ACTIVE:  read_next = 16'(active);
         ADDR_VECTOR:  read_next = vector;
         default:      read_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_reg  <= '0;
         mask_reg     <= '0;
         edge_sel_reg <= EDGE_DEFAULT[N_SRC-1:0];
         irq_prev_reg <= '0;
         readdata     <= '0;
         cpu_irq      <= 1'b0;
      end else begin
         pending_reg  <= pending_next;
         irq_prev_reg <= irq_src;
         if (wr_en && address == ADDR_MASK) mask_reg <= wdata;
         if (wr_en && address == ADDR_EDGE) edge_sel_reg <= wdata;
         readdata     <= read_next;
         cpu_irq      <= |active;
      end
   end

endmodule
